cu_fsm: RTL and testbench

CU_FSM -- requirements
Module: cu_fsm

---
 rtl/otter_pkg.sv | 39 +++
 rtl/cu_fsm.sv | 163 ++++++++++++++++
 tb/tb_cu_fsm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pkg
//  Description : Shared types for the OTTER control path: RV32 major opcodes,
//                control-unit state encoding and SYSTEM func3 codes. Used by
//                the control FSM and by the instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_pkg;

   // RV32I major opcodes (ir[6:0])
   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP_RG3 = 7'b0110011,
      SYSTEM = 7'b1110011
   } opcode_t;

   // Control-unit states
   typedef enum logic [2:0] {
      INIT  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      INTR  = 3'd4
   } state_t;

   // SYSTEM-opcode func3 selections recognised by the control unit
   localparam logic [2:0] F3_MRET  = 3'b000;
   localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage : otter_pkg
`default_nettype wire

// File: rtl/cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cu_fsm
//  Description : OTTER multi-cycle control unit. Sequences register-file
//                clear, instruction fetch, execute, load write-back and
//                interrupt entry; all datapath strobes are combinational
//                from state, opcode, func3 and mem_ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_fsm
   import otter_pkg::*;
#(
   parameter int INIT_CYCLES = 2    // rf_rst cycles after reset release, 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       intr,
   input  logic       mie,
   input  logic       mem_ack,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_we2,
   output logic       mem_rden1,
   output logic       mem_rden2,
   output logic       rf_rst,
   output logic       csr_we,
   output logic       int_taken,
   output logic       mret_exec
);

   localparam logic [3:0] CNT_RST = 4'(INIT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q,   cnt_d;
   logic       pend_q,  pend_d;

   logic       irq;        // qualified interrupt request this cycle
   logic       done;       // instruction completes this cycle
   logic       is_mret;    // completing instruction is MRET

   assign irq = intr & mie;

   // State, INIT down-counter and interrupt-pending flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= CNT_RST;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state, counter, pending flag and datapath strobes
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q | irq;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_we2   = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      rf_rst    = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      done      = 1'b0;
      is_mret   = 1'b0;

      case (state_q)
         INIT: begin
            rf_rst = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = FETCH;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         FETCH: begin
            mem_rden1 = 1'b1;
            if (mem_ack) begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            case (opcode)
               LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  done      = 1'b1;
               end
               LOAD: begin
                  // Issue the data read here; completion happens in WB
                  mem_rden2 = 1'b1;
                  state_d   = WB;
               end
               STORE: begin
                  mem_we2 = 1'b1;
                  if (mem_ack) begin
                     pc_write = 1'b1;
                     done     = 1'b1;
                  end
               end
               SYSTEM: begin
                  pc_write = 1'b1;
                  done     = 1'b1;
                  if (func3 == F3_CSRRW) begin
                     csr_we    = 1'b1;
                     reg_write = 1'b1;
                  end else if (func3 == F3_MRET) begin
                     mret_exec = 1'b1;
                     is_mret   = 1'b1;
                  end
               end
               default: begin
                  // BRANCH and every unrecognised opcode only advance the PC
                  pc_write = 1'b1;
                  done     = 1'b1;
               end
            endcase
         end

         WB: begin
            mem_rden2 = 1'b1;
            if (mem_ack) begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               done      = 1'b1;
            end
         end

         INTR: begin
            int_taken = 1'b1;
            pc_write  = 1'b1;
            state_d   = FETCH;
         end

         default: begin
            state_d = INIT;
            cnt_d   = CNT_RST;
         end
      endcase

      // MRET never chains straight into interrupt entry; a pending request
      // stays latched and is taken after the following instruction.
      if (done) begin
         state_d = ((pend_q | irq) && !is_mret) ? INTR : FETCH;
      end

      if (state_d == INTR) begin
         pend_d = 1'b0;
      end
   end

endmodule : cu_fsm
`default_nettype wire

// File: tb/tb_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cu_fsm
//  Description : Directed self-checking bench for cu_fsm (INIT_CYCLES = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_fsm;

   // Strobe bit positions in the packed observation vector
   localparam logic [8:0] S_PC   = 9'h100;
   localparam logic [8:0] S_RW   = 9'h080;
   localparam logic [8:0] S_WE   = 9'h040;
   localparam logic [8:0] S_RD1  = 9'h020;
   localparam logic [8:0] S_RD2  = 9'h010;
   localparam logic [8:0] S_RF   = 9'h008;
   localparam logic [8:0] S_CSR  = 9'h004;
   localparam logic [8:0] S_INT  = 9'h002;
   localparam logic [8:0] S_MRET = 9'h001;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_NOP    = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       intr, mie, mem_ack;
   logic       pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
   logic       rf_rst, csr_we, int_taken, mret_exec;
   logic [8:0] strobes;

   int total = 0;
   int bad   = 0;

   cu_fsm #(.INIT_CYCLES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .func3     (func3),
      .intr      (intr),
      .mie       (mie),
      .mem_ack   (mem_ack),
      .pc_write  (pc_write),
      .reg_write (reg_write),
      .mem_we2   (mem_we2),
      .mem_rden1 (mem_rden1),
      .mem_rden2 (mem_rden2),
      .rf_rst    (rf_rst),
      .csr_we    (csr_we),
      .int_taken (int_taken),
      .mret_exec (mret_exec)
   );

   always #5 clk = ~clk;

   assign strobes = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
                     rf_rst, csr_we, int_taken, mret_exec};

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Let inputs settle, then compare all strobes
   task automatic chk(input string tag, input logic [8:0] exp);
      #1;
      total++;
      assert (strobes === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, strobes, exp);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      opcode  = OPC_NOP;
      func3   = 3'b000;
      intr    = 1'b0;
      mie     = 1'b0;
      mem_ack = 1'b0;

      // Reset state
      chk("reset", S_RF);
      tick();
      tick();

      // Release: two INIT cycles, then FETCH
      rst_n = 1'b1;
      chk("init1", S_RF);
      tick(); chk("init2", S_RF);
      tick(); chk("fetch_wait", S_RD1);
      tick(); chk("fetch_hold", S_RD1);

      // ADDI x1,x0,5: ack in first FETCH cycle -> EXEC with pc/reg write
      opcode = OPC_OPIMM; func3 = 3'b000; mem_ack = 1'b1;
      chk("addi_fetch", S_RD1);
      tick(); mem_ack = 1'b0; chk("addi_exec", S_PC | S_RW);
      tick(); chk("addi_next", S_RD1);

      // LW with ack in the third WB cycle
      opcode = OPC_LOAD; func3 = 3'b010; mem_ack = 1'b1;
      chk("lw_fetch", S_RD1);
      tick(); mem_ack = 1'b0; chk("lw_exec", S_RD2);
      tick(); chk("lw_wb1", S_RD2);
      tick(); chk("lw_wb2", S_RD2);
      tick(); mem_ack = 1'b1; chk("lw_ack", S_RD2 | S_RW | S_PC);
      tick(); mem_ack = 1'b0; chk("lw_next", S_RD1);

      // One-cycle interrupt pulse in FETCH with mie=1, then SW completes
      intr = 1'b1; mie = 1'b1;
      chk("sw_fetch_irq", S_RD1);
      tick(); intr = 1'b0; opcode = OPC_STORE; mem_ack = 1'b1;
      chk("sw_fetch_ack", S_RD1);
      tick(); mem_ack = 1'b0; chk("sw_wait", S_WE);
      tick(); mem_ack = 1'b1; chk("sw_ack", S_WE | S_PC);
      tick(); mem_ack = 1'b0; chk("intr_entry", S_INT | S_PC);
      tick(); chk("intr_fetch", S_RD1);

      // Same with mie=0: no interrupt entry
      intr = 1'b1; mie = 1'b0; mem_ack = 1'b1;
      chk("sw2_fetch", S_RD1);
      tick(); intr = 1'b0; chk("sw2_ack", S_WE | S_PC);
      tick(); mem_ack = 1'b0; chk("no_intr", S_RD1);

      // Opcode 0 executes as a one-cycle NOP; stray ack not used
      opcode = OPC_NOP; mem_ack = 1'b1;
      chk("nop_fetch", S_RD1);
      tick(); chk("nop_exec", S_PC);
      tick(); mem_ack = 1'b0; chk("nop_next", S_RD1);

      // CSRRW
      opcode = OPC_SYSTEM; func3 = 3'b001; mem_ack = 1'b1;
      chk("csr_fetch", S_RD1);
      tick(); mem_ack = 1'b0; chk("csrrw_exec", S_CSR | S_RW | S_PC);
      tick(); chk("csrrw_next", S_RD1);

      // MRET with an interrupt raised in its completion cycle: no INTR
      // straight away, the latched request is taken after the next NOP.
      func3 = 3'b000; mem_ack = 1'b1;
      chk("mret_fetch", S_RD1);
      tick(); mem_ack = 1'b0; intr = 1'b1; mie = 1'b1;
      chk("mret_exec", S_MRET | S_PC);
      tick(); intr = 1'b0; opcode = OPC_NOP; mem_ack = 1'b1;
      chk("mret_no_intr", S_RD1);
      tick(); mem_ack = 1'b0; chk("pend_nop", S_PC);
      tick(); chk("pend_intr", S_INT | S_PC);
      tick(); mie = 1'b0; chk("pend_fetch", S_RD1);

      // Reset asserted in the second WB wait cycle, ack coincident
      opcode = OPC_LOAD; func3 = 3'b010; mem_ack = 1'b1;
      chk("lw2_fetch", S_RD1);
      tick(); mem_ack = 1'b0; chk("lw2_exec", S_RD2);
      tick(); chk("lw2_wb1", S_RD2);
      tick(); rst_n = 1'b0; mem_ack = 1'b1; chk("rst_mid_wb", S_RF);
      tick(); mem_ack = 1'b0; chk("rst_hold", S_RF);
      tick(); rst_n = 1'b1; chk("reinit1", S_RF);
      tick(); chk("reinit2", S_RF);
      tick(); chk("refetch", S_RD1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cu_fsm
`default_nettype wire
